// File: rtl/flood_open.sv
`default_nettype none
// ============================================================================
// Module   : flood_open
// Purpose  : Open/flag front-end for the cover board with BFS flood fill of
//            zero-count cells via a circular work queue.
//            Optional FLOOD_OPEN_STATS_EN adds the open_count output.
// Revision : 1.0
// ============================================================================
module flood_open #(
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int X_COORD_BITS = 4,
    parameter int Y_COORD_BITS = 4,
    parameter int QUEUE_DEPTH  = 64,
    parameter int QUEUE_BITS   = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ui_open,
    input  logic                    ui_flag,
    input  logic [X_COORD_BITS-1:0] ui_x,
    input  logic [Y_COORD_BITS-1:0] ui_y,
    output logic                    flag,
    output logic                    open,
    output logic [X_COORD_BITS-1:0] x_coord,
    output logic [Y_COORD_BITS-1:0] y_coord,
    input  logic                    opened_cell,
    output logic [X_COORD_BITS-1:0] cnt_x,
    output logic [Y_COORD_BITS-1:0] cnt_y,
    input  logic [3:0]              cnt_val,
    output logic                    busy,
    output logic                    done,
    output logic                    mine_hit,
    output logic                    overflow
`ifdef FLOOD_OPEN_STATS_EN
    ,
    output logic [X_COORD_BITS+Y_COORD_BITS:0] open_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_OPEN   = 3'd2,
        S_CHECK  = 3'd3,
        S_PUSH   = 3'd4,
        S_POP    = 3'd5
    } state_t;

    localparam logic [X_COORD_BITS:0] c_x_size  = X_SIZE[X_COORD_BITS:0];
    localparam logic [Y_COORD_BITS:0] c_y_size  = Y_SIZE[Y_COORD_BITS:0];
    localparam logic [QUEUE_BITS:0]   c_q_depth = QUEUE_DEPTH[QUEUE_BITS:0];
    localparam logic [X_COORD_BITS:0] c_x_m1    = '1;
    localparam logic [X_COORD_BITS:0] c_x_p1    = {{X_COORD_BITS{1'b0}}, 1'b1};
    localparam logic [Y_COORD_BITS:0] c_y_m1    = '1;
    localparam logic [Y_COORD_BITS:0] c_y_p1    = {{Y_COORD_BITS{1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_next;
    logic [X_COORD_BITS-1:0] r_cur_x;
    logic [Y_COORD_BITS-1:0] r_cur_y;
    logic [3:0]              r_cur_cnt;
    logic [2:0]              r_nbr_idx;
    logic [QUEUE_BITS-1:0]   r_wr_ptr;
    logic [QUEUE_BITS-1:0]   r_rd_ptr;
    logic [QUEUE_BITS:0]     r_count;
    logic                    r_overflow;
    logic [X_COORD_BITS-1:0] r_q_x [QUEUE_DEPTH];
    logic [Y_COORD_BITS-1:0] r_q_y [QUEUE_DEPTH];

    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_flush;
    logic                    w_q_full;
    logic                    w_q_empty;
    logic                    w_in_bounds;
    logic [X_COORD_BITS:0]   w_dx;
    logic [Y_COORD_BITS:0]   w_dy;
    logic [X_COORD_BITS:0]   w_nx;
    logic [Y_COORD_BITS:0]   w_ny;

    assign busy      = (r_state != S_IDLE);
    assign cnt_x     = r_cur_x;
    assign cnt_y     = r_cur_y;
    assign overflow  = r_overflow;
    assign w_q_full  = (r_count == c_q_depth);
    assign w_q_empty = (r_count == '0);

    // Neighbour offsets in raster order around cur; -1 is all-ones so that
    // stepping left/up from 0 lands far outside the board instead of wrapping.
    always_comb begin
        w_dx = '0;
        w_dy = '0;
        case (r_nbr_idx)
            3'd0: begin w_dx = c_x_m1; w_dy = c_y_m1; end
            3'd1: begin w_dx = '0;     w_dy = c_y_m1; end
            3'd2: begin w_dx = c_x_p1; w_dy = c_y_m1; end
            3'd3: begin w_dx = c_x_m1; w_dy = '0;     end
            3'd4: begin w_dx = c_x_p1; w_dy = '0;     end
            3'd5: begin w_dx = c_x_m1; w_dy = c_y_p1; end
            3'd6: begin w_dx = '0;     w_dy = c_y_p1; end
            default: begin w_dx = c_x_p1; w_dy = c_y_p1; end
        endcase
    end

    assign w_nx        = {1'b0, r_cur_x} + w_dx;
    assign w_ny        = {1'b0, r_cur_y} + w_dy;
    assign w_in_bounds = (w_nx < c_x_size) && (w_ny < c_y_size);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        flag     = 1'b0;
        open     = 1'b0;
        x_coord  = r_cur_x;
        y_coord  = r_cur_y;
        done     = 1'b0;
        mine_hit = 1'b0;
        w_accept = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_flush  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ui_open && !ui_flag) begin
                    w_accept = 1'b1;
                    w_next   = S_LOOKUP;
                end else if (ui_flag && !ui_open) begin
                    flag    = 1'b1;
                    x_coord = ui_x;
                    y_coord = ui_y;
                end
            end
            S_LOOKUP: w_next = S_OPEN;
            S_OPEN: begin
                open   = 1'b1;
                w_next = S_CHECK;
            end
            S_CHECK: begin
                if (opened_cell && (r_cur_cnt == 4'd9)) begin
                    mine_hit = 1'b1;
                    done     = 1'b1;
                    w_flush  = 1'b1;
                    w_next   = S_IDLE;
                end else if (opened_cell && (r_cur_cnt == 4'd0)) begin
                    w_next = S_PUSH;
                end else begin
                    w_next = S_POP;
                end
            end
            S_PUSH: begin
                w_push = w_in_bounds;
                if (r_nbr_idx == 3'd7) begin
                    w_next = S_POP;
                end
            end
            S_POP: begin
                if (w_q_empty) begin
                    done   = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_pop  = 1'b1;
                    w_next = S_LOOKUP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_cur_cnt  <= '0;
            r_nbr_idx  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur_x    <= ui_x;
                r_cur_y    <= ui_y;
                r_overflow <= 1'b0;
            end
            if (r_state == S_OPEN) begin
                r_cur_cnt <= cnt_val;
            end
            if (r_state == S_CHECK) begin
                r_nbr_idx <= '0;
            end else if (r_state == S_PUSH) begin
                r_nbr_idx <= r_nbr_idx + 3'd1;
            end
            if (w_push) begin
                if (w_q_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + {{(QUEUE_BITS-1){1'b0}}, 1'b1};
                    r_count  <= r_count + {{QUEUE_BITS{1'b0}}, 1'b1};
                end
            end
            if (w_pop) begin
                r_cur_x  <= r_q_x[r_rd_ptr];
                r_cur_y  <= r_q_y[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + {{(QUEUE_BITS-1){1'b0}}, 1'b1};
                r_count  <= r_count - {{QUEUE_BITS{1'b0}}, 1'b1};
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end
        end
    end

    // Queue storage needs no reset: emptiness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push && !w_q_full) begin
            r_q_x[r_wr_ptr] <= w_nx[X_COORD_BITS-1:0];
            r_q_y[r_wr_ptr] <= w_ny[Y_COORD_BITS-1:0];
        end
    end

`ifdef FLOOD_OPEN_STATS_EN
    logic [X_COORD_BITS+Y_COORD_BITS:0] r_open_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_open_count <= '0;
        end else if (w_accept) begin
            r_open_count <= '0;
        end else if ((r_state == S_CHECK) && opened_cell) begin
            r_open_count <= r_open_count + {{(X_COORD_BITS+Y_COORD_BITS){1'b0}}, 1'b1};
        end
    end

    assign open_count = r_open_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flood_open.sv
`default_nettype none
// ============================================================================
// Module   : tb_flood_open
// Purpose  : Directed self-checking bench for flood_open with a behavioural
//            cover board and mine-count board. Uses a 4-entry work queue.
// Revision : 1.0
// ============================================================================
module tb_flood_open;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ui_open = 1'b0;
    logic       ui_flag = 1'b0;
    logic [3:0] ui_x = '0;
    logic [3:0] ui_y = '0;
    logic       flag, open, busy, done, mine_hit, overflow;
    logic [3:0] x_coord, y_coord, cnt_x, cnt_y;
    logic       opened_cell = 1'b0;
    logic [3:0] cnt_val = '0;
`ifdef FLOOD_OPEN_STATS_EN
    logic [8:0] open_count;
`endif

    always #5 clk = ~clk;

    flood_open #(
        .X_SIZE(16), .Y_SIZE(16), .X_COORD_BITS(4), .Y_COORD_BITS(4),
        .QUEUE_DEPTH(4), .QUEUE_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .ui_open(ui_open), .ui_flag(ui_flag),
        .ui_x(ui_x), .ui_y(ui_y), .flag(flag), .open(open),
        .x_coord(x_coord), .y_coord(y_coord), .opened_cell(opened_cell),
        .cnt_x(cnt_x), .cnt_y(cnt_y), .cnt_val(cnt_val), .busy(busy),
        .done(done), .mine_hit(mine_hit), .overflow(overflow)
`ifdef FLOOD_OPEN_STATS_EN
        , .open_count(open_count)
`endif
    );

    // Behavioural boards: count lookup with 1-cycle latency, cover board that
    // acknowledges only the first open of each cell.
    logic [3:0] board [256];
    logic [255:0] opened = '0;
    logic       clr_req = 1'b0;

    always @(posedge clk) begin
        cnt_val     <= board[{cnt_y, cnt_x}];
        opened_cell <= open && !opened[{y_coord, x_coord}];
        if (clr_req) opened <= '0;
        else if (open) opened[{y_coord, x_coord}] <= 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fresh_board(input logic [3:0] v);
        for (int i = 0; i < 256; i++) board[i] = v;
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
    endtask

    int n_open, n_done, n_mine, n_flag, done_k, mine_k, first_k;
    int busy1, ovf1, ovf_seen, ovf_done, post_busy, post_done;
    int ox[$];
    int oy[$];

    task automatic run_op(input int x, input int y, input int budget);
        n_open = 0; n_done = 0; n_mine = 0; n_flag = 0;
        done_k = -1; mine_k = -1; first_k = -1;
        busy1 = 0; ovf1 = 0; ovf_seen = 0; ovf_done = 0;
        ox.delete(); oy.delete();
        @(negedge clk);
        ui_x = 4'(x); ui_y = 4'(y); ui_open = 1'b1;
        @(posedge clk);
        #1 ui_open = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) begin busy1 = int'(busy); ovf1 = int'(overflow); end
            if (open) begin
                n_open++;
                if (first_k < 0) first_k = k;
                ox.push_back(int'(x_coord));
                oy.push_back(int'(y_coord));
            end
            if (flag) n_flag++;
            if (mine_hit) begin n_mine++; mine_k = k; end
            if (overflow) ovf_seen = 1;
            if (done) begin
                n_done++; done_k = k; ovf_done = int'(overflow);
                break;
            end
        end
        @(negedge clk);
        post_busy = int'(busy);
        post_done = int'(done);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) board[i] = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_open", int'(open), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(overflow), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_flag", int'(flag), 0);
        check("rst_mine", int'(mine_hit), 0);

        // Single non-zero cell
        fresh_board(4'd1);
        board[4*16+3] = 4'd2;
        run_op(3, 4, 50);
        check("t1_nopen", n_open, 1);
        check("t1_x", ox.size() > 0 ? ox[0] : -1, 3);
        check("t1_y", oy.size() > 0 ? oy[0] : -1, 4);
        check("t1_open_k", first_k, 2);
        check("t1_done_k", done_k, 4);
        check("t1_busy1", busy1, 1);
        check("t1_post_busy", post_busy, 0);
        check("t1_post_done", post_done, 0);
        check("t1_mine", n_mine, 0);

        // Corner zero cell: (0,0),(1,0),(0,1),(1,1)
        fresh_board(4'd1);
        board[0] = 4'd0;
        run_op(0, 0, 200);
        check("t2_nopen", n_open, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_x%0d", i), i < ox.size() ? ox[i] : -1, i % 2);
            check($sformatf("t2_y%0d", i), i < oy.size() ? oy[i] : -1, i / 2);
        end
        check("t2_done_k", done_k, 24);
        check("t2_ndone", n_done, 1);
        check("t2_ovf", ovf_seen, 0);
        check("t2_flag", n_flag, 0);

        // Mine on the requested cell
        fresh_board(4'd1);
        board[5*16+5] = 4'd9;
        run_op(5, 5, 50);
        check("t3_nopen", n_open, 1);
        check("t3_open_k", first_k, 2);
        check("t3_nmine", n_mine, 1);
        check("t3_mine_k", mine_k, 3);
        check("t3_done_k", done_k, 3);
        check("t3_post_busy", post_busy, 0);

        // Mine reached by flood with queued work pending: queue must flush
        fresh_board(4'd1);
        board[0] = 4'd0;
        board[1] = 4'd9;
        run_op(0, 0, 200);
        check("t3b_nopen", n_open, 2);
        check("t3b_done_k", done_k, 15);
        check("t3b_nmine", n_mine, 1);
        run_op(9, 9, 200);
        check("t3b_after_nopen", n_open, 1);
        check("t3b_after_done_k", done_k, 4);

        // Already-opened cell, then flag while idle
        fresh_board(4'd1);
        run_op(3, 4, 50);
        run_op(3, 4, 50);
        check("t4_nopen", n_open, 1);
        check("t4_done_k", done_k, 4);
        check("t4_post_busy", post_busy, 0);
        @(negedge clk);
        ui_x = 4'd2; ui_y = 4'd2; ui_flag = 1'b1;
        #1;
        check("t4_flag", int'(flag), 1);
        check("t4_flag_x", int'(x_coord), 2);
        check("t4_flag_y", int'(y_coord), 2);
        check("t4_flag_open", int'(open), 0);
        @(posedge clk);
        #1 ui_flag = 1'b0;
        @(negedge clk);
        check("t4_flag_once", int'(flag), 0);
        check("t4_flag_busy", int'(busy), 0);
        check("t4_flag_done", int'(done), 0);
        // Both requests together are ignored
        ui_open = 1'b1; ui_flag = 1'b1;
        #1;
        check("t4_both_flag", int'(flag), 0);
        @(posedge clk);
        #1 begin ui_open = 1'b0; ui_flag = 1'b0; end
        @(negedge clk);
        check("t4_both_busy", int'(busy), 0);

        // All-zero board overflows the 4-entry queue
        fresh_board(4'd0);
        run_op(0, 0, 30000);
        check("t5_ndone", n_done, 1);
        check("t5_ovf_seen", ovf_seen, 1);
        check("t5_ovf_done", ovf_done, 1);
        @(negedge clk);
        check("t5_ovf_sticky", int'(overflow), 1);
        run_op(0, 0, 50);
        check("t5_ovf_clr", ovf1, 0);
        check("t5_re_done_k", done_k, 4);

        // Reset asserted in the middle of PUSH
        fresh_board(4'd1);
        board[5*16+5] = 4'd0;
        @(negedge clk);
        ui_x = 4'd5; ui_y = 4'd5; ui_open = 1'b1;
        @(posedge clk);
        #1 ui_open = 1'b0;
        repeat (9) @(negedge clk);
        check("t6_busy_push", int'(busy), 1);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("t6_busy", int'(busy), 0);
        check("t6_open", int'(open), 0);
        check("t6_done", int'(done), 0);
        run_op(9, 9, 50);
        check("t6_nopen", n_open, 1);
        check("t6_x", ox.size() > 0 ? ox[0] : -1, 9);
        check("t6_done_k", done_k, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flood_open.md
Name: flood_open

Overview:
- Sits directly upstream of the cover board and drives its flag, open and coordinate inputs.
- Accepts single open/flag requests from the cursor/UI layer.
- When an opened cell has zero adjacent mines, it automatically opens all in-bounds neighbours through an internal FIFO work queue (breadth-first flood fill).
- Reads adjacent-mine counts from the mine-count board through a 1-cycle-latency lookup port.

Parameters:
- x_size, 16, board width in cells
- y_size, 16, board height in cells
- x_coord_bits, 4, x coordinate width
- y_coord_bits, 4, y coordinate width
- queue_depth, 64, work-queue entries (power of two)
- queue_bits, 6, log2(queue_depth)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ui_open  in  1  open request pulse (valid only when busy=0)
- ui_flag  in  1  flag-toggle request pulse (valid only when busy=0)
- ui_x  in  x_coord_bits  request x
- ui_y  in  y_coord_bits  request y
- flag  out  1  to cover board
- open  out  1  to cover board
- x_coord  out  x_coord_bits  to cover board
- y_coord  out  y_coord_bits  to cover board
- opened_cell  in  1  from cover board; high the cycle after a successful open
- cnt_x  out  x_coord_bits  count lookup address
- cnt_y  out  y_coord_bits  count lookup address
- cnt_val  in  4  adjacent count, valid 1 cycle after address; 9 = mine
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the operation completes
- mine_hit  out  1  one-cycle pulse when an opened cell holds a mine
- overflow  out  1  sticky; set on a dropped push, cleared on the next accepted ui_open

Behaviour:
- Reset (reset=0 at a clk edge) clears all outputs, empties the queue and forces state IDLE. It takes effect mid-flood with no further open pulses.
- States: IDLE, LOOKUP, OPEN, CHECK, PUSH, POP.
- IDLE:
  - ui_open=1 with ui_flag=0: latch (ui_x,ui_y) into cur, clear overflow, go to LOOKUP.
  - ui_flag=1 with ui_open=0: drive flag=1 with x/y = ui coords for exactly one cycle; stay IDLE; no done.
  - Both asserted: ignored.
  - Requests while busy are ignored.
- LOOKUP: cnt_x/cnt_y = cur for one cycle; cnt_val is registered into cur_cnt at the next edge; go to OPEN.
- OPEN: open=1, x_coord/y_coord = cur, for exactly one cycle; go to CHECK.
- CHECK: sample opened_cell.
  - opened_cell=0 (cell already opened or flagged): no action.
  - opened_cell=1 and cur_cnt=9: pulse mine_hit, flush the queue, pulse done, go to IDLE.
  - opened_cell=1 and cur_cnt=0: nbr_idx=0, go to PUSH.
  - Otherwise (including the opened_cell=0 case): go to POP.
- PUSH: one cycle per nbr_idx, 0..7, regardless of bounds.
  - Offset order: (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1).
  - Out-of-bounds neighbours (x<0, x>=x_size, y<0, y>=y_size) are skipped.
  - Bounds are computed at x_coord_bits+1 / y_coord_bits+1 width; no wrap-around.
  - Queue full: the entry is dropped and overflow is set.
  - After idx 7, go to POP.
- POP:
  - Queue empty: pulse done, go to IDLE.
  - Otherwise: dequeue into cur, go to LOOKUP.
- Queue: circular FIFO with separate read/write pointers plus a count. Only one operation per cycle (push in PUSH, pop in POP), so no simultaneous read/write. Duplicate entries are permitted; they are harmless because the cover board reports opened_cell=0 for them.
- Outputs open and flag are 0 in every state/cycle not listed above.
- Latency:
  - Single non-zero cell: ui_open at edge N; open high during cycle N+2; done high during cycle N+4.
  - Zero cell: 8 extra PUSH cycles, then 4 cycles per dequeued cell plus 8 per further zero cell.

Optional Feature:
- Macro: FLOOD_OPEN_STATS_EN.
- Defined: adds output open_count [x_coord_bits+y_coord_bits:0].
  - Cleared when ui_open is accepted.
  - Incremented in each CHECK cycle with opened_cell=1.
  - Holds its value after done until the next accepted ui_open.
  - Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ui_open (3,4), cnt_val=2, opened_cell returned -> exactly one open pulse at (3,4); done 2 cycles later; busy low after; no mine_hit.
- ui_open (0,0), cnt(0,0)=0, all other cells 1 -> opens in order (0,0),(1,0),(0,1),(1,1); no out-of-bounds coordinates ever driven; single done.
- ui_open (5,5), cnt=9 -> open at (5,5), mine_hit pulse, done same cycle, queue empty afterwards.
- ui_open at an already-opened cell (opened_cell stays 0) -> one open pulse, no PUSH, done; then ui_flag at (2,2) while idle -> single flag pulse at (2,2).
- All-zero 16x16 board with queue_depth=4 -> overflow set and stays set until the next ui_open; the operation still terminates with done.
- reset=0 during PUSH -> next cycle busy=0, open=0, queue empty; a subsequent ui_open behaves as after power-up.
